drops_btn_conditioner: RTL and testbench

- Input front-end of the drops game. Sits between the raw button pins (ui_in[1:0]) and the game-logic core.
- Synchronises and debounces two push-buttons, then arbitrates direction.
- Emits single-cycle move-left / move-right pulses, with optional auto-repeat while a button is held.
- Output is consumed directly by the player-position logic.

---
 rtl/drops_pkg.sv | 28 ++
 rtl/drops_debounce.sv | 63 ++++++
 rtl/drops_btn_conditioner.sv | 165 ++++++++++++++++
 tb/tb_drops_btn_conditioner.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/drops_pkg.sv
// drops_pkg: shared types and helpers for the drops button front-end.
//   dir_state_e : direction FSM state, 2-bit encoding
//   BTN_LEFT    : bit index of the left button in the 2-bit button vectors
//   BTN_RIGHT   : bit index of the right button in the 2-bit button vectors
//   cnt_width() : counter width able to hold a given maximum count, plus one bit
//   max2()      : larger of two parameter values
package drops_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLD_L  = 2'd1,
      HOLD_R  = 2'd2,
      BLOCKED = 2'd3
   } dir_state_e;

   localparam int unsigned BTN_LEFT  = 1;
   localparam int unsigned BTN_RIGHT = 0;

   // The extra bit keeps full-width compares safe when max_val is a power of two.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return $clog2(max_val) + 1;
   endfunction

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/drops_debounce.sv
// drops_debounce: 2-FF synchroniser followed by a debounce counter for one button.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   ena_i   : low = synchronous clear of every flop
//   raw_i   : raw asynchronous button level
//   level_o : debounced level; changes only after DEBOUNCE_CYCLES consecutive
//             synchronised samples disagree with the current level
module drops_debounce
   import drops_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena_i,
   input  logic raw_i,
   output logic level_o
);

   localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta_q;
   logic          sync_q;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The counter measures how long the synchronised input has disagreed with
   // the stable level; any agreement restarts the measurement.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = ~stable_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q   <= 1'b0;
         sync_q   <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else if (!ena_i) begin
         meta_q   <= 1'b0;
         sync_q   <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         meta_q   <= raw_i;
         sync_q   <= meta_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign level_o = stable_q;

endmodule

// File: rtl/drops_btn_conditioner.sv
// drops_btn_conditioner: button front-end of the drops game.
// Debounces the two raw buttons, arbitrates direction and emits one-cycle
// move pulses. Defining DROPS_AUTOREPEAT_EN adds auto-repeat pulses while a
// single button stays held.
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   ena          : low = synchronous clear, outputs idle
//   btn_raw_i    : raw buttons, bit1 = left, bit0 = right, active high
//   move_left_o  : one-cycle pulse, move player left
//   move_right_o : one-cycle pulse, move player right
//   btn_level_o  : debounced button levels, same bit mapping
//   blocked_o    : high while the direction FSM sits in BLOCKED
module drops_btn_conditioner
   import drops_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned REPEAT_DELAY    = 250000,
   parameter int unsigned REPEAT_PERIOD   = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [1:0] btn_raw_i,
   output logic       move_left_o,
   output logic       move_right_o,
   output logic [1:0] btn_level_o,
   output logic       blocked_o
);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("drops_btn_conditioner: parameter below its minimum");
   end

   logic [1:0] stable;
   logic [1:0] level_q;
   dir_state_e state_q, state_d;
   logic       left_q, left_d;
   logic       right_q, right_d;
   logic       rep_hit;
   logic       lvl_l, lvl_r;

   drops_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena_i   (ena),
      .raw_i   (btn_raw_i[BTN_LEFT]),
      .level_o (stable[BTN_LEFT])
   );

   drops_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena_i   (ena),
      .raw_i   (btn_raw_i[BTN_RIGHT]),
      .level_o (stable[BTN_RIGHT])
   );

   assign lvl_l = stable[BTN_LEFT];
   assign lvl_r = stable[BTN_RIGHT];

`ifdef DROPS_AUTOREPEAT_EN
   localparam int unsigned RW = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rep_cnt_q, rep_cnt_d;
   // 0 while waiting out the initial delay, 1 once periodic repeat has begun.
   logic          rep_periodic_q, rep_periodic_d;

   // Runs only while the FSM stays in the same HOLD state; entering a hold or
   // leaving it clears everything, which also aborts a pending repeat.
   always_comb begin
      rep_cnt_d      = '0;
      rep_periodic_d = 1'b0;
      rep_hit        = 1'b0;
      if ((state_q == HOLD_L || state_q == HOLD_R) && state_d == state_q) begin
         rep_hit = rep_periodic_q ? (rep_cnt_q == PERIOD_LAST) : (rep_cnt_q == DELAY_LAST);
         if (rep_hit) begin
            rep_cnt_d      = '0;
            rep_periodic_d = 1'b1;
         end else begin
            rep_cnt_d      = rep_cnt_q + RW'(1);
            rep_periodic_d = rep_periodic_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt_q      <= '0;
         rep_periodic_q <= 1'b0;
      end else if (!ena) begin
         rep_cnt_q      <= '0;
         rep_periodic_q <= 1'b0;
      end else begin
         rep_cnt_q      <= rep_cnt_d;
         rep_periodic_q <= rep_periodic_d;
      end
   end
`else
   assign rep_hit = 1'b0;
`endif

   // State register, plus the registered pulses and level copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         left_q  <= 1'b0;
         right_q <= 1'b0;
         level_q <= 2'b00;
      end else if (!ena) begin
         state_q <= IDLE;
         left_q  <= 1'b0;
         right_q <= 1'b0;
         level_q <= 2'b00;
      end else begin
         state_q <= state_d;
         left_q  <= left_d;
         right_q <= right_d;
         level_q <= stable;
      end
   end

   // Next state. BLOCKED only re-arms once both buttons are released.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (lvl_l && lvl_r)  state_d = BLOCKED;
            else if (lvl_l)      state_d = HOLD_L;
            else if (lvl_r)      state_d = HOLD_R;
         end
         HOLD_L: begin
            if (lvl_r)           state_d = BLOCKED;
            else if (!lvl_l)     state_d = IDLE;
         end
         HOLD_R: begin
            if (lvl_l)           state_d = BLOCKED;
            else if (!lvl_r)     state_d = IDLE;
         end
         BLOCKED: begin
            if (!lvl_l && !lvl_r) state_d = IDLE;
         end
         default:                state_d = IDLE;
      endcase
   end

   // Pulse on hold entry, and on a repeat hit only while the hold continues.
   always_comb begin
      left_d  = 1'b0;
      right_d = 1'b0;
      if (state_d == HOLD_L) begin
         left_d = (state_q == IDLE) || (state_q == HOLD_L && rep_hit);
      end
      if (state_d == HOLD_R) begin
         right_d = (state_q == IDLE) || (state_q == HOLD_R && rep_hit);
      end
   end

   assign move_left_o  = left_q;
   assign move_right_o = right_q;
   assign btn_level_o  = level_q;
   assign blocked_o    = (state_q == BLOCKED);

endmodule

// File: tb/tb_drops_btn_conditioner.sv
module tb_drops_btn_conditioner;

   localparam int DB  = 4;
   localparam int RD  = 20;
   localparam int RP  = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic [1:0] btn_raw_i = 2'b00;
   logic       move_left_o;
   logic       move_right_o;
   logic [1:0] btn_level_o;
   logic       blocked_o;

   always #5 clk = ~clk;

   drops_btn_conditioner #(
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .btn_raw_i    (btn_raw_i),
      .move_left_o  (move_left_o),
      .move_right_o (move_right_o),
      .btn_level_o  (btn_level_o),
      .blocked_o    (blocked_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at time %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model, kept in terms of the behavioural rules: a debounced
   // level flips once the last DB synchronised samples all disagree with it;
   // the direction logic is a set of press/hold/conflict rules; repeats are
   // counted as cycles held since the press.
   bit [1:0] m_raw_hist[$];
   bit [1:0] m_sync_hist[$];
   bit [1:0] m_stable;
   bit [1:0] m_level;
   int       m_mode;     // 0 nothing held, 1 left owns, 2 right owns, 3 conflict
   int       m_held;
   bit       m_left;
   bit       m_right;

   function automatic void model_clear();
      m_raw_hist.delete();
      m_sync_hist.delete();
      m_stable = 2'b00;
      m_level  = 2'b00;
      m_mode   = 0;
      m_held   = 0;
      m_left   = 1'b0;
      m_right  = 1'b0;
   endfunction

   function automatic void model_edge(input bit en, input bit [1:0] raw);
      bit [1:0] s;
      bit       l, r;
      int       prev;
      bit       all_diff;
      if (!en) begin
         model_clear();
         return;
      end
      // Synchronised value seen at this edge is the raw sample from two edges back.
      s = (m_raw_hist.size() >= 2) ? m_raw_hist[m_raw_hist.size()-2] : 2'b00;
      m_raw_hist.push_back(raw);
      if (m_raw_hist.size() > 2) void'(m_raw_hist.pop_front());
      m_sync_hist.push_back(s);
      if (m_sync_hist.size() > DB) void'(m_sync_hist.pop_front());

      l = m_stable[1];
      r = m_stable[0];
      prev = m_mode;
      m_left  = 1'b0;
      m_right = 1'b0;
      case (m_mode)
         0: begin
            if (l && r) m_mode = 3;
            else if (l) begin m_mode = 1; m_left = 1'b1; end
            else if (r) begin m_mode = 2; m_right = 1'b1; end
         end
         1: if (r) m_mode = 3; else if (!l) m_mode = 0;
         2: if (l) m_mode = 3; else if (!r) m_mode = 0;
         default: if (!l && !r) m_mode = 0;
      endcase
      if ((m_mode == 1 || m_mode == 2) && prev == m_mode) begin
         m_held++;
`ifdef DROPS_AUTOREPEAT_EN
         if (m_held == RD || (m_held > RD && (m_held - RD) % RP == 0)) begin
            if (m_mode == 1) m_left = 1'b1;
            else             m_right = 1'b1;
         end
`endif
      end else begin
         m_held = 0;
      end
      m_level = m_stable;

      for (int b = 0; b < 2; b++) begin
         all_diff = (m_sync_hist.size() == DB);
         foreach (m_sync_hist[k]) if (m_sync_hist[k][b] == m_stable[b]) all_diff = 1'b0;
         if (all_diff) m_stable[b] = ~m_stable[b];
      end
   endfunction

   // Per-test observation records.
   int edge_no;
   int lq[$];
   int rq[$];
   int first_blk;
   int first_lvl;

   task automatic start_test();
      edge_no = -1;
      lq.delete();
      rq.delete();
      first_blk = -1;
      first_lvl = -1;
   endtask

   task automatic step();
      @(posedge clk);
      edge_no++;
      model_edge(ena, btn_raw_i);
      #1;
      check_eq("level",   {30'd0, btn_level_o}, {30'd0, m_level});
      check_eq("left",    {31'd0, move_left_o}, {31'd0, m_left});
      check_eq("right",   {31'd0, move_right_o}, {31'd0, m_right});
      check_eq("blocked", {31'd0, blocked_o}, {31'd0, (m_mode == 3)});
      check_eq("excl",    {31'd0, move_left_o & move_right_o}, 32'd0);
      if (move_left_o)  lq.push_back(edge_no);
      if (move_right_o) rq.push_back(edge_no);
      if (blocked_o && first_blk < 0) first_blk = edge_no;
      if (btn_level_o != 2'b00 && first_lvl < 0) first_lvl = edge_no;
   endtask

   task automatic hold(input logic [1:0] raw, input int n);
      btn_raw_i = raw;
      repeat (n) step();
   endtask

   int exp5[6] = '{6, 26, 34, 42, 50, 58};
   int n_seg;

   initial begin
      model_clear();
      start_test();
      rst_n = 1'b0;
      ena   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_left",    {31'd0, move_left_o}, 32'd0);
      check_eq("rst_right",   {31'd0, move_right_o}, 32'd0);
      check_eq("rst_level",   {30'd0, btn_level_o}, 32'd0);
      check_eq("rst_blocked", {31'd0, blocked_o}, 32'd0);
      rst_n = 1'b1;
      ena   = 1'b1;
      repeat (3) step();

      // 1: left press held 40 cycles
      start_test();
      hold(2'b10, 40);
      check_eq("t1_level_edge", first_lvl, 6);
`ifdef DROPS_AUTOREPEAT_EN
      check_eq("t1_left_count", lq.size(), 3);
`else
      check_eq("t1_left_count", lq.size(), 1);
`endif
      if (lq.size() > 0) check_eq("t1_left_edge", lq[0], 6);
      hold(2'b00, 12);

      // 2: 3-cycle glitch on right
      start_test();
      hold(2'b01, 3);
      hold(2'b00, 15);
      check_eq("t2_level_edge", first_lvl, -1);
      check_eq("t2_right_count", rq.size(), 0);

      // 3: conflict handling
      start_test();
      hold(2'b10, 10);
      hold(2'b11, 10);
      check_eq("t3_blocked", {31'd0, blocked_o}, 32'd1);
      check_eq("t3_no_right", rq.size(), 0);
      hold(2'b10, 10);
      check_eq("t3_still_blocked", {31'd0, blocked_o}, 32'd1);
      check_eq("t3_left_count", lq.size(), 1);
      hold(2'b00, 10);
      check_eq("t3_released", {31'd0, blocked_o}, 32'd0);
      hold(2'b01, 10);
      check_eq("t3_right_count", rq.size(), 1);
      hold(2'b00, 12);

      // 4: simultaneous press
      start_test();
      hold(2'b11, 10);
      check_eq("t4_blocked_edge", first_blk, 6);
      check_eq("t4_pulses", lq.size() + rq.size(), 0);
      hold(2'b00, 12);

`ifdef DROPS_AUTOREPEAT_EN
      // 5: auto-repeat on right
      start_test();
      hold(2'b01, 60);
      check_eq("t5_right_count", rq.size(), 6);
      foreach (exp5[i]) if (i < rq.size()) check_eq("t5_right_edge", rq[i], exp5[i]);
      hold(2'b00, 20);
      check_eq("t5_after_release", rq.size(), 6);
`endif

      // 6: async reset mid-hold, then ena gating
      start_test();
      hold(2'b10, 10);
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      check_eq("t6_rst_left",    {31'd0, move_left_o}, 32'd0);
      check_eq("t6_rst_level",   {30'd0, btn_level_o}, 32'd0);
      check_eq("t6_rst_blocked", {31'd0, blocked_o}, 32'd0);
      #3;
      rst_n = 1'b1;
      ena   = 1'b0;
      start_test();
      hold(2'b10, 5);
      check_eq("t6_ena_low_pulses", lq.size(), 0);
      check_eq("t6_ena_low_level", {30'd0, btn_level_o}, 32'd0);
      ena = 1'b1;
      start_test();
      hold(2'b10, 10);
      check_eq("t6_left_count", lq.size(), 1);
      if (lq.size() > 0) check_eq("t6_left_edge", lq[0], 6);
      hold(2'b00, 12);

      // Randomised segments, checked cycle by cycle against the model.
      for (int i = 0; i < 250; i++) begin
         btn_raw_i = 2'($urandom_range(0, 3));
         ena = ($urandom_range(0, 19) != 0);
         n_seg = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 10);
         repeat (n_seg) step();
      end
      ena = 1'b1;
      hold(2'b00, 12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
